// File: rtl/fifo_ip.sv
// Single-clock synchronous FIFO with registered (normal-mode) read data.
// Occupancy counter drives usedw; full/empty flags are registered from the next count.
module fifo_ip #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic [WIDTH-1:0]           data,
  input  logic                       wrreq,
  input  logic                       rdreq,
  output logic [WIDTH-1:0]           q,
  output logic                       wrfull,
  output logic                       rdempty,
  output logic [$clog2(DEPTH):0]     usedw
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             wr_acc;
  logic             rd_acc;

  // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc  = rdreq && !rdempty;
    wr_acc  = wrreq && (!wrfull || rd_acc);
    cnt_nxt = cnt;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aclr && wr_acc) begin
      mem[wptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      q       <= '0;
      wrfull  <= 1'b0;
      rdempty <= 1'b1;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_acc) begin
        q    <= mem[rptr];
        rptr <= rptr + AW'(1);
      end
      cnt     <= cnt_nxt;
      wrfull  <= (cnt_nxt == CW'(DEPTH));
      rdempty <= (cnt_nxt == '0);
    end
  end

  assign usedw = cnt;

endmodule

// File: tb/tb_fifo_ip.sv
// Directed self-checking bench for fifo_ip: reset, fill/drain, overflow/underflow,
// simultaneous access, pointer wrap and mid-stream reset.
module tb_fifo_ip;

  logic       clk;
  logic       aclr;
  logic [7:0] data;
  logic       wrreq;
  logic       rdreq;
  logic [7:0] q;
  logic       wrfull;
  logic       rdempty;
  logic [3:0] usedw;

  int checks = 0;
  int errors = 0;

  fifo_ip #(.WIDTH(8), .DEPTH(8)) dut (
    .clk     (clk),
    .aclr    (aclr),
    .data    (data),
    .wrreq   (wrreq),
    .rdreq   (rdreq),
    .q       (q),
    .wrfull  (wrfull),
    .rdempty (rdempty),
    .usedw   (usedw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wrreq = w;
    rdreq = r;
    data  = d;
    @(posedge clk);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] exp_q;
    logic [7:0] model [$];
    logic       ra;
    logic       wa;

    aclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data = '0;

    // Reset
    step(1'b0, 1'b0, 8'h00);
    aclr = 1'b0;
    chk("reset_rdempty", rdempty, 1);
    chk("reset_wrfull",  wrfull,  0);
    chk("reset_usedw",   usedw,   0);
    chk("reset_q",       q,       8'h00);

    // Fill
    for (int i = 0; i < 8; i++) begin
      v = 8'(1 << i);
      step(1'b1, 1'b0, v);
      chk("fill_wrfull",  wrfull,  (i == 7) ? 1 : 0);
      chk("fill_usedw",   usedw,   i + 1);
      chk("fill_rdempty", rdempty, 0);
    end

    // Overflow write is dropped
    step(1'b1, 1'b0, 8'hFF);
    chk("ovf_wrfull", wrfull, 1);
    chk("ovf_usedw",  usedw,  8);

    // Drain
    for (int i = 0; i < 8; i++) begin
      v = 8'(1 << i);
      step(1'b0, 1'b1, 8'h00);
      chk("drain_q",       q,       v);
      chk("drain_rdempty", rdempty, (i == 7) ? 1 : 0);
      chk("drain_usedw",   usedw,   7 - i);
      chk("drain_wrfull",  wrfull,  0);
    end

    // Underflow read is ignored
    step(1'b0, 1'b1, 8'h00);
    chk("udf_q",       q,       8'h80);
    chk("udf_usedw",   usedw,   0);
    chk("udf_rdempty", rdempty, 1);

    // Simultaneous read+write while full
    for (int i = 0; i < 8; i++) begin
      v = 8'(1 << i);
      step(1'b1, 1'b0, v);
    end
    chk("refill_wrfull", wrfull, 1);
    step(1'b1, 1'b1, 8'hAA);
    chk("simfull_q",      q,      8'h01);
    chk("simfull_wrfull", wrfull, 1);
    chk("simfull_usedw",  usedw,  8);
    for (int i = 1; i < 9; i++) begin
      v = (i == 8) ? 8'hAA : 8'(1 << i);
      step(1'b0, 1'b1, 8'h00);
      chk("simfull_drain_q", q, v);
    end
    chk("simfull_drain_empty", rdempty, 1);

    // Simultaneous read+write while empty: only the write is taken
    step(1'b1, 1'b1, 8'h55);
    chk("simempty_usedw",   usedw,   1);
    chk("simempty_q",       q,       8'hAA);
    chk("simempty_rdempty", rdempty, 0);
    step(1'b0, 1'b1, 8'h00);
    chk("simempty_read_q",     q,       8'h55);
    chk("simempty_read_empty", rdempty, 1);

    // Interleaved traffic across pointer wrap, checked against a queue model
    exp_q = 8'h55;
    for (int k = 0; k < 20; k++) begin
      v  = 8'(8'h30 + k);
      ra = (k % 3 != 0) && (model.size() > 0);
      wa = (k % 4 != 3) && ((model.size() < 8) || ra);
      step((k % 4 != 3), (k % 3 != 0), v);
      if (ra) exp_q = model.pop_front();
      if (wa) model.push_back(v);
      chk("wrap_q",       q,       exp_q);
      chk("wrap_usedw",   usedw,   model.size());
      chk("wrap_rdempty", rdempty, (model.size() == 0) ? 1 : 0);
    end

    // Reset mid-stream with requests active
    step(1'b1, 1'b0, 8'hEE);
    aclr = 1'b1;
    step(1'b1, 1'b1, 8'hDD);
    aclr = 1'b0;
    chk("midrst_usedw",   usedw,   0);
    chk("midrst_rdempty", rdempty, 1);
    chk("midrst_wrfull",  wrfull,  0);
    chk("midrst_q",       q,       8'h00);
    step(1'b1, 1'b0, 8'h5A);
    chk("postrst_usedw", usedw, 1);
    step(1'b0, 1'b1, 8'h00);
    chk("postrst_q",     q,       8'h5A);
    chk("postrst_empty", rdempty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
